// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller: pending/mask/overrun registers and an IDLE/REQUEST/SERVICE handshake FSM.
// Optional macro IRQ_EDGE_DETECT_EN: qualify events on rising edges of irq_in instead of its level.
module interrupt_controller #(
    parameter int WIDTH = 8,
    localparam int ID_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] irq_in,
    input  logic             mask_we,
    input  logic [WIDTH-1:0] mask_in,
    input  logic             ack,
    input  logic             eoi,
    input  logic             ovr_clr,
    output logic             irq,
    output logic [ID_W-1:0]  irq_id,
    output logic             in_service,
    output logic [WIDTH-1:0] pending,
    output logic [WIDTH-1:0] overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] overrun_q, overrun_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;

    logic [WIDTH-1:0] event_w;
    logic [WIDTH-1:0] active_w;
    logic [WIDTH-1:0] clear_w;
    logic [ID_W-1:0]  top_id;
    logic             ack_req;

`ifdef IRQ_EDGE_DETECT_EN
    logic [WIDTH-1:0] irq_prev_q, irq_prev_d;

    always_comb begin
        irq_prev_d = irq_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev_q <= '0;
        end else begin
            irq_prev_q <= irq_prev_d;
        end
    end

    assign event_w = irq_in & ~irq_prev_q;
`else
    assign event_w = irq_in;
`endif

    assign active_w = pending_q & mask_q;
    assign ack_req  = (state_q == REQUEST) && ack;

    // Ascending scan so the last hit, i.e. the highest index, wins.
    always_comb begin
        top_id = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (active_w[i]) begin
                top_id = i[ID_W-1:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_clear
            assign clear_w[gi] = ack_req && (irq_id_q == ID_W'(gi));
        end
    endgenerate

    // A new event beats the ack clear; a new overrun beats ovr_clr.
    always_comb begin
        pending_d = event_w | (pending_q & ~clear_w);
        overrun_d = (event_w & pending_q & ~clear_w) | (overrun_q & ~{WIDTH{ovr_clr}});
        mask_d    = mask_we ? mask_in : mask_q;
    end

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            IDLE: begin
                if (|active_w) begin
                    state_d  = REQUEST;
                    irq_id_d = top_id;
                end
            end
            REQUEST: begin
                if (ack) begin
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            irq_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            irq_id_q  <= irq_id_d;
        end
    end

    assign irq        = (state_q == REQUEST);
    assign in_service = (state_q == SERVICE);
    assign irq_id     = irq_id_q;
    assign pending    = pending_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: a per-edge reference model queues expected outputs, a monitor compares them.
module tb_interrupt_controller;

    localparam int W   = 8;
    localparam int IDW = 3;

    typedef struct packed {
        logic           irq;
        logic [IDW-1:0] id;
        logic           svc;
        logic [W-1:0]   pend;
        logic [W-1:0]   ovr;
    } obs_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [W-1:0]   irq_in = '0;
    logic           mask_we = 1'b0;
    logic [W-1:0]   mask_in = '0;
    logic           ack = 1'b0;
    logic           eoi = 1'b0;
    logic           ovr_clr = 1'b0;
    logic           irq;
    logic [IDW-1:0] irq_id;
    logic           in_service;
    logic [W-1:0]   pending;
    logic [W-1:0]   overrun;

    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t exp_q[$];

    // Reference model: plain per-line arrays plus a phase number.
    localparam int PH_IDLE = 0, PH_REQ = 1, PH_SVC = 2;
    bit m_pend[W];
    bit m_mask[W];
    bit m_ovr[W];
    bit m_prev[W];
    int m_phase = PH_IDLE;
    int m_id = 0;

    always #5 clk = ~clk;

    interrupt_controller #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .irq_in(irq_in),
        .mask_we(mask_we),
        .mask_in(mask_in),
        .ack(ack),
        .eoi(eoi),
        .ovr_clr(ovr_clr),
        .irq(irq),
        .irq_id(irq_id),
        .in_service(in_service),
        .pending(pending),
        .overrun(overrun)
    );

    function automatic obs_t mk(input logic i, input int id, input logic s,
                                input logic [W-1:0] p, input logic [W-1:0] o);
        obs_t r;
        r.irq  = i;
        r.id   = IDW'(id);
        r.svc  = s;
        r.pend = p;
        r.ovr  = o;
        return r;
    endfunction

    function automatic obs_t model_obs();
        obs_t r;
        r.irq = (m_phase == PH_REQ);
        r.svc = (m_phase == PH_SVC);
        r.id  = IDW'(m_id);
        for (int i = 0; i < W; i++) begin
            r.pend[i] = m_pend[i];
            r.ovr[i]  = m_ovr[i];
        end
        return r;
    endfunction

    function automatic obs_t dut_obs();
        obs_t r;
        r.irq  = irq;
        r.id   = irq_id;
        r.svc  = in_service;
        r.pend = pending;
        r.ovr  = overrun;
        return r;
    endfunction

    // Advance the model by one clock edge with the given inputs.
    task automatic model_edge(input logic [W-1:0] i_irq, input logic i_mwe, input logic [W-1:0] i_mask,
                              input logic i_ack, input logic i_eoi, input logic i_oc, input logic i_rst);
        int  served;
        int  best;
        bit  ev;
        if (i_rst) begin
            for (int i = 0; i < W; i++) begin
                m_pend[i] = 0; m_mask[i] = 0; m_ovr[i] = 0; m_prev[i] = 0;
            end
            m_phase = PH_IDLE;
            m_id    = 0;
        end else begin
            served = (m_phase == PH_REQ && i_ack) ? m_id : -1;
            best = -1;
            for (int i = 0; i < W; i++) begin
                if (m_pend[i] && m_mask[i]) best = i;
            end
            for (int i = 0; i < W; i++) begin
`ifdef IRQ_EDGE_DETECT_EN
                ev = i_irq[i] && !m_prev[i];
`else
                ev = i_irq[i];
`endif
                if (ev && m_pend[i] && i != served) m_ovr[i] = 1;
                else if (i_oc) m_ovr[i] = 0;
                if (ev) m_pend[i] = 1;
                else if (i == served) m_pend[i] = 0;
                if (i_mwe) m_mask[i] = i_mask[i];
                m_prev[i] = i_irq[i];
            end
            if (m_phase == PH_IDLE && best >= 0) begin
                m_phase = PH_REQ;
                m_id    = best;
            end else if (m_phase == PH_REQ && i_ack) begin
                m_phase = PH_SVC;
            end else if (m_phase == PH_SVC && i_eoi) begin
                m_phase = PH_IDLE;
            end
        end
    endtask

    task automatic step(input logic [W-1:0] i_irq, input logic i_mwe, input logic [W-1:0] i_mask,
                        input logic i_ack, input logic i_eoi, input logic i_oc, input logic i_rst);
        @(negedge clk);
        irq_in  = i_irq;
        mask_we = i_mwe;
        mask_in = i_mask;
        ack     = i_ack;
        eoi     = i_eoi;
        ovr_clr = i_oc;
        reset   = i_rst;
        model_edge(i_irq, i_mwe, i_mask, i_ack, i_eoi, i_oc, i_rst);
        exp_q.push_back(model_obs());
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Directed check against a hand-derived constant, sampled after the next edge.
    task automatic spot(input string name, input obs_t want);
        obs_t got;
        @(posedge clk);
        #2;
        got = dut_obs();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL spot %s: got irq=%0b id=%0d svc=%0b pend=%h ovr=%h, want irq=%0b id=%0d svc=%0b pend=%h ovr=%h",
                     name, got.irq, got.id, got.svc, got.pend, got.ovr,
                     want.irq, want.id, want.svc, want.pend, want.ovr);
        end else begin
            $display("spot %s ok: irq=%0b id=%0d svc=%0b pend=%h ovr=%h",
                     name, got.irq, got.id, got.svc, got.pend, got.ovr);
        end
    endtask

    // Monitor: every edge that had stimulus queued is compared against the model.
    initial begin
        obs_t want;
        obs_t got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = dut_obs();
                n_cmp++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL monitor t=%0t: got irq=%0b id=%0d svc=%0b pend=%h ovr=%h, want irq=%0b id=%0d svc=%0b pend=%h ovr=%h",
                             $time, got.irq, got.id, got.svc, got.pend, got.ovr,
                             want.irq, want.id, want.svc, want.pend, want.ovr);
                end else begin
                    $display("mon t=%0t ok: irq=%0b id=%0d svc=%0b pend=%h ovr=%h",
                             $time, got.irq, got.id, got.svc, got.pend, got.ovr);
                end
            end
        end
    end

    initial begin
        // Reset with arbitrary inputs
        repeat (2) step(W'($urandom), 1'b1, W'($urandom), 1'b1, 1'b1, 1'b1, 1'b1);
        spot("reset", mk(0, 0, 0, 8'h00, 8'h00));

        // Basic flow
        step('0, 1'b1, 8'h80, 0, 0, 0, 0);
        step(8'h80, 0, '0, 0, 0, 0, 0);
        spot("basic_pending", mk(0, 0, 0, 8'h80, 8'h00));
        idle(1);
        spot("basic_irq", mk(1, 7, 0, 8'h80, 8'h00));
        step('0, 0, '0, 1, 0, 0, 0);
        spot("basic_ack", mk(0, 7, 1, 8'h00, 8'h00));
        step('0, 0, '0, 0, 1, 0, 0);
        spot("basic_eoi", mk(0, 7, 0, 8'h00, 8'h00));

        // Priority
        step('0, 1'b1, 8'hFF, 0, 0, 0, 0);
        step(8'h81, 0, '0, 0, 0, 0, 0);
        idle(1);
        spot("prio_first", mk(1, 7, 0, 8'h81, 8'h00));
        step('0, 0, '0, 1, 0, 0, 0);
        step('0, 0, '0, 0, 1, 0, 0);
        idle(1);
        spot("prio_second", mk(1, 0, 0, 8'h01, 8'h00));
        step('0, 0, '0, 1, 0, 0, 0);
        step('0, 0, '0, 0, 1, 0, 0);

        // Mask
        step('0, 1'b1, 8'h00, 0, 0, 0, 0);
        step(8'h08, 0, '0, 0, 0, 0, 0);
        idle(2);
        spot("mask_held", mk(0, 0, 0, 8'h08, 8'h00));
        step('0, 1'b1, 8'h08, 0, 0, 0, 0);
        spot("mask_wait", mk(0, 0, 0, 8'h08, 8'h00));
        idle(1);
        spot("mask_irq", mk(1, 3, 0, 8'h08, 8'h00));
        step('0, 0, '0, 1, 0, 0, 0);
        step('0, 0, '0, 0, 1, 0, 0);

        // Overrun
        step('0, 1'b1, 8'h80, 0, 0, 0, 0);
        step(8'h80, 0, '0, 0, 0, 0, 0);
        step(8'h80, 0, '0, 0, 0, 0, 0);
        spot("ovr_set", mk(1, 7, 0, 8'h80, 8'h80));
        step('0, 0, '0, 0, 0, 1, 0);
        spot("ovr_clr", mk(1, 7, 0, 8'h80, 8'h00));
        step(8'h80, 0, '0, 1, 0, 0, 0);
        spot("ovr_ack_coincide", mk(0, 7, 1, 8'h80, 8'h00));
        step('0, 0, '0, 0, 1, 0, 0);
        idle(1);
        step('0, 0, '0, 1, 0, 0, 0);
        step('0, 0, '0, 0, 1, 0, 0);
        step(8'h80, 0, '0, 0, 0, 0, 0);
        step(8'h80, 0, '0, 0, 0, 1, 0);
        spot("ovr_beats_clr", mk(1, 7, 0, 8'h80, 8'h80));
        step('0, 0, '0, 1, 0, 0, 0);
        step('0, 0, '0, 0, 1, 0, 1'b1 & 1'b0);
        step('0, 0, '0, 0, 0, 1, 0);

        // Held line, single ack, then reset in SERVICE
        step('0, 1'b1, 8'h04, 0, 0, 0, 0);
        step(8'h04, 0, '0, 0, 0, 0, 0);
        step(8'h04, 0, '0, 0, 0, 0, 0);
        step(8'h04, 0, '0, 1, 0, 0, 0);
`ifdef IRQ_EDGE_DETECT_EN
        spot("held_after_ack", mk(0, 2, 1, 8'h00, 8'h00));
`else
        spot("held_after_ack", mk(0, 2, 1, 8'h04, 8'h04));
`endif
        step(8'h04, 0, '0, 0, 0, 0, 0);
        step(8'h04, 0, '0, 0, 0, 0, 0);
        step(8'h04, 1'b1, 8'hFF, 1, 1, 1, 1);
        spot("reset_in_service", mk(0, 0, 0, 8'h00, 8'h00));

        // Randomised traffic
        for (int k = 0; k < 1500; k++) begin
            step(W'($urandom & $urandom & $urandom),
                 ($urandom_range(0, 9) == 0),
                 W'($urandom),
                 ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 99) == 0));
        end

        repeat (3) @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the number of interrupt lines (legal range 2..32).
REQ-002 SHALL have localparam ID_W = $clog2(WIDTH), giving the width of the interrupt index.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port irq_in  input  WIDTH  interrupt event lines, e.g. single-cycle pulses from a timer on bit WIDTH-1.
REQ-006 SHALL have port mask_we  input  1  write strobe for the mask register.
REQ-007 SHALL have port mask_in  input  WIDTH  mask write data; 1 = line enabled.
REQ-008 SHALL have port ack  input  1  CPU accepts the presented interrupt.
REQ-009 SHALL have port eoi  input  1  CPU end-of-interrupt.
REQ-010 SHALL have port ovr_clr  input  1  clears all overrun flags.
REQ-011 SHALL have port irq  output  1  interrupt request to the CPU.
REQ-012 SHALL have port irq_id  output  ID_W  index of the presented interrupt.
REQ-013 SHALL have port in_service  output  1  an interrupt is being serviced.
REQ-014 SHALL have port pending  output  WIDTH  pending register.
REQ-015 SHALL have port overrun  output  WIDTH  lost-event flags.

Function
REQ-016 A qualified event on line i SHALL set pending[i] on the next edge, independent of mask.
REQ-017 mask_we SHALL load mask from mask_in on the next edge; the new mask SHALL qualify requests from the following cycle.
REQ-018 The FSM SHALL have states IDLE, REQUEST and SERVICE.
REQ-019 In IDLE, if (pending & mask) != 0, the FSM SHALL latch irq_id = the highest set index (bit WIDTH-1 has highest priority) and SHALL go to REQUEST.
REQ-020 In REQUEST, irq SHALL be 1 and irq_id SHALL stay frozen until ack, even if the mask changes.
REQ-021 ack in REQUEST SHALL clear pending[irq_id] and SHALL move the FSM to SERVICE.
REQ-022 In SERVICE, irq SHALL be 0 and in_service SHALL be 1; eoi SHALL return the FSM to IDLE.
REQ-023 Latency: an event sampled at edge N SHALL give pending at N+1 and irq=1 at N+2.
REQ-024 ack outside REQUEST and eoi outside SERVICE SHALL be ignored.
REQ-025 When a new event on line i coincides with the ack clear of line i, the set SHALL win: pending[i] stays 1 and overrun[i] is not set.
REQ-026 overrun[i] SHALL be set when a qualified event arrives while pending[i]=1 and pending[i] is not being cleared that cycle.
REQ-027 overrun SHALL be cleared only by ovr_clr or reset; when a new overrun coincides with ovr_clr, the overrun SHALL win.
REQ-028 irq SHALL never be asserted while in_service=1; there is no nesting.

Reset
REQ-029 reset SHALL force the FSM to IDLE and clear mask, pending, overrun, irq, irq_id and in_service to 0 on the next edge, from any state including mid-REQUEST or mid-SERVICE.
REQ-030 reset SHALL take priority over every simultaneous input.

Configuration
REQ-031 Macro IRQ_EDGE_DETECT_EN defined: a qualified event SHALL be a rising edge of irq_in[i] (a registered previous value, reset to 0), so a held-high line yields exactly one event.
REQ-032 Macro IRQ_EDGE_DETECT_EN undefined: a qualified event SHALL be irq_in[i]=1 on any cycle (level-qualified), and no previous-value register SHALL exist.

Verification
REQ-033 Reset: drive reset for 2 cycles with arbitrary inputs -> all outputs 0 and FSM in IDLE.
REQ-034 Basic flow: mask=8'h80; pulse irq_in=8'h80 at edge 10 -> pending=8'h80 at 11, irq=1 and irq_id=7 at 12; ack at 14 -> pending=0, irq=0, in_service=1 at 15; eoi -> in_service=0.
REQ-035 Priority: mask=8'hFF; pulse irq_in=8'h81 -> irq_id=7 first; after ack and eoi -> irq_id=0.
REQ-036 Mask: mask=8'h00; pulse bit 3 -> pending=8'h08 and irq stays 0; write mask=8'h08 -> irq=1 with irq_id=3 two edges after the write.
REQ-037 Overrun: pulse bit 7 twice before ack -> overrun=8'h80; pulse bit 7 coincident with ack -> pending[7]=1 and no new overrun; ovr_clr -> overrun=0.
REQ-038 Edge detect and mid-service reset: hold irq_in[2] high for 5 cycles and ack once -> with the macro, pending[2]=0 after the ack; without the macro, pending[2] re-sets. Then assert reset during SERVICE -> all outputs 0 on the next edge.
